apb_rr_arbiter: RTL and testbench

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

---
 rtl/apb_arb_pkg.sv | 16 +
 rtl/apb_rr_picker.sv | 40 ++++
 rtl/apb_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and default sizing for the APB round-robin arbiter.
package apb_arb_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_AW      = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 15;

    // Transfer phases of the APB master.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: searches upward from last_owner+1,
// wrapping, and returns the first requester found.
module apb_rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    int          cand;
    logic [IW-1:0] cand_idx;

    // Scan from the farthest offset down to the nearest so the nearest
    // requester after last_owner is the one left standing.
    always_comb begin
        grant    = '0;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = int'(last_owner) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (req[cand_idx]) begin
                grant           = '0;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
                valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// APB master shared by NREQ requesters with round-robin arbitration,
// latched transfer attributes and a bounded wait for pready.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic [DW-1:0]      prdata,
    input  logic               pready,
    input  logic               pslverr
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e    state_reg, state_next;
    logic [IW-1:0] owner_reg;
    logic [IW-1:0] last_owner_reg;
    logic [CW-1:0] wait_cnt_reg;
    logic          pwrite_reg;
    logic [AW-1:0] paddr_reg;
    logic [DW-1:0] pwdata_reg;
    logic [DW-1:0] rdata_reg;
    logic          err_reg;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            timeout_hit;

    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
        end
    endgenerate

    apb_rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req        (req),
        .last_owner (last_owner_reg),
        .grant      (pick_grant),
        .idx        (pick_idx),
        .valid      (pick_valid)
    );

    assign pwrite = pwrite_reg;
    assign paddr  = paddr_reg;
    assign pwdata = pwdata_reg;
    assign rdata  = rdata_reg;
    assign err    = err_reg;

    // Next-state and APB/handshake outputs; the last allowed wait cycle
    // ends the transfer just like a pready would, but flagged as an error.
    always_comb begin
        state_next  = state_reg;
        psel        = 1'b0;
        penable     = 1'b0;
        gnt         = '0;
        done        = '0;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                psel           = 1'b1;
                gnt[owner_reg] = 1'b1;
                state_next     = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel           = 1'b1;
                penable        = 1'b1;
                gnt[owner_reg] = 1'b1;
                if (pready) begin
                    done[owner_reg] = 1'b1;
                    state_next      = ST_IDLE;
                end else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
                    done[owner_reg] = 1'b1;
                    timeout_hit     = 1'b1;
                    state_next      = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus transfer latch, completion status and wait counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= '0;
            last_owner_reg <= IW'(NREQ - 1);
            wait_cnt_reg   <= '0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    wait_cnt_reg <= '0;
                    if (pick_valid) begin
                        owner_reg  <= pick_idx;
                        pwrite_reg <= req_wr[pick_idx];
                        paddr_reg  <= addr_arr[pick_idx];
                        pwdata_reg <= wdata_arr[pick_idx];
                    end
                end
                ST_ACCESS: begin
                    if (pready) begin
                        if (!pwrite_reg) begin
                            rdata_reg <= prdata;
                        end
                        err_reg        <= pslverr;
                        last_owner_reg <= owner_reg;
                        wait_cnt_reg   <= '0;
                    end else if (timeout_hit) begin
                        err_reg        <= 1'b1;
                        last_owner_reg <= owner_reg;
                        wait_cnt_reg   <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level round-robin model.
module tb_apb_rr_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_wr;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rdata;
    logic               err;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic [DW-1:0]      prdata;
    logic               pready;
    logic               pslverr;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state
    int            m_last;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;

    always #5 clk = ~clk;

    apb_rr_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .err(err), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        rstn = 1'b0; req = '0; pready = 1'b0; pslverr = 1'b0;
        tick();
        m_last = NREQ - 1; exp_rdata = '0; exp_err = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rstn = 1'b0; req = '1; req_wr = '1; req_addr = '1; req_wdata = '1;
        pready = 1'b1; pslverr = 1'b1; prdata = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            checks++; if (psel !== 1'b0) begin failures++; $display("FAIL reset_psel got=%b exp=0", psel); end
            checks++; if (penable !== 1'b0) begin failures++; $display("FAIL reset_penable got=%b exp=0", penable); end
            checks++; if (gnt !== '0 || done !== '0) begin failures++; $display("FAIL reset_gnt_done gnt=%b done=%b exp=0", gnt, done); end
            checks++; if (pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0) begin failures++; $display("FAIL reset_apb pwrite=%b paddr=%h pwdata=%h exp=0", pwrite, paddr, pwdata); end
            checks++; if (rdata !== '0 || err !== 1'b0) begin failures++; $display("FAIL reset_status rdata=%h err=%b exp=0", rdata, err); end
        end
        m_last = NREQ - 1; exp_rdata = '0; exp_err = 1'b0;
        req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; pready = 1'b0; pslverr = 1'b0;
    endtask

    task automatic test_single_write();
        // cycle 1: IDLE with request
        tick();
        rstn = 1'b1; req = 4'b0001; req_wr = 4'b0001;
        req_addr = '0; req_addr[0 +: AW] = 4'h3;
        req_wdata = '0; req_wdata[0 +: DW] = 8'hA5;
        @(negedge clk);
        checks++; if (psel !== 1'b0) begin failures++; $display("FAIL wr_c1_psel got=%b exp=0", psel); end
        // cycle 2: SETUP
        tick();
        @(negedge clk);
        checks++; if (psel !== 1'b1 || penable !== 1'b0) begin failures++; $display("FAIL wr_c2_setup psel=%b penable=%b exp=1/0", psel, penable); end
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wr_c2_gnt got=%b exp=0001", gnt); end
        // cycle 3: ACCESS, slave ready at once
        tick();
        pready = 1'b1;
        @(negedge clk);
        checks++; if (penable !== 1'b1) begin failures++; $display("FAIL wr_c3_penable got=%b exp=1", penable); end
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL wr_c3_done got=%b exp=0001", done); end
        checks++; if (pwrite !== 1'b1 || paddr !== 4'h3 || pwdata !== 8'hA5) begin failures++; $display("FAIL wr_c3_apb pwrite=%b paddr=%h pwdata=%h exp=1/3/a5", pwrite, paddr, pwdata); end
        // cycle 4: back in IDLE
        tick();
        req = '0; pready = 1'b0;
        @(negedge clk);
        checks++; if (psel !== 1'b0 || done !== '0 || err !== 1'b0) begin failures++; $display("FAIL wr_c4_idle psel=%b done=%b err=%b exp=0", psel, done, err); end
        checks++; if (paddr !== 4'h3 || pwdata !== 8'hA5) begin failures++; $display("FAIL wr_c4_hold paddr=%h pwdata=%h exp=3/a5", paddr, pwdata); end
        m_last = 0; exp_err = 1'b0;
    endtask

    task automatic test_read_wait();
        logic [DW-1:0] rd_seq [3];
        rd_seq[0] = 8'h00; rd_seq[1] = 8'hFF; rd_seq[2] = 8'h5C;
        tick();
        req = 4'b0010; req_wr = 4'b0000; req_addr[1*AW +: AW] = 4'h7;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (gnt !== 4'b0010 || pwrite !== 1'b0) begin failures++; $display("FAIL rd_setup gnt=%b pwrite=%b exp=0010/0", gnt, pwrite); end
        for (int w = 0; w < 3; w++) begin
            tick();
            pready = (w == 2); prdata = rd_seq[w];
            @(negedge clk);
            checks++; if (done !== ((w == 2) ? 4'b0010 : 4'b0000)) begin failures++; $display("FAIL rd_done_w%0d got=%b exp=%b", w, done, (w == 2) ? 4'b0010 : 4'b0000); end
        end
        tick();
        req = '0; pready = 1'b0; prdata = 8'h11;
        @(negedge clk);
        checks++; if (rdata !== 8'h5C || err !== 1'b0) begin failures++; $display("FAIL rd_result rdata=%h err=%b exp=5c/0", rdata, err); end
        m_last = 1; exp_rdata = 8'h5C; exp_err = 1'b0;
    endtask

    task automatic test_slverr();
        // errored write from requester 2
        tick();
        req = 4'b0100; req_wr = 4'b0100;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        pready = 1'b1; pslverr = 1'b1; prdata = 8'hEE;
        @(negedge clk);
        checks++; if (done !== 4'b0100) begin failures++; $display("FAIL slv_done got=%b exp=0100", done); end
        tick();
        req = '0; pready = 1'b0; pslverr = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b1 || rdata !== exp_rdata) begin failures++; $display("FAIL slv_err err=%b rdata=%h exp=1/%h", err, rdata, exp_rdata); end
        // clean read from requester 3 clears err
        tick();
        req = 4'b1000; req_wr = 4'b0000;
        @(negedge clk);
        tick();
        pslverr = 1'b1;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL slv_setup_hold err=%b exp=1", err); end
        tick();
        pready = 1'b1; pslverr = 1'b0; prdata = 8'h3C;
        @(negedge clk);
        tick();
        req = '0; pready = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0 || rdata !== 8'h3C) begin failures++; $display("FAIL slv_clear err=%b rdata=%h exp=0/3c", err, rdata); end
        m_last = 3; exp_rdata = 8'h3C; exp_err = 1'b0;
    endtask

    task automatic test_rr_order();
        int order [5];
        logic [NREQ-1:0] exp_g;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        apply_reset();
        tick();
        rstn = 1'b1; req = '1; req_wr = '1; pready = 1'b1; prdata = 8'h99;
        for (int t = 0; t < 5; t++) begin
            exp_g = '0; exp_g[order[t]] = 1'b1;
            @(negedge clk);
            checks++; if (psel !== 1'b0) begin failures++; $display("FAIL rr_idle_t%0d psel=%b exp=0", t, psel); end
            tick();
            @(negedge clk);
            checks++; if (gnt !== exp_g || penable !== 1'b0) begin failures++; $display("FAIL rr_setup_t%0d gnt=%b penable=%b exp=%b/0", t, gnt, penable, exp_g); end
            tick();
            @(negedge clk);
            checks++; if (done !== exp_g) begin failures++; $display("FAIL rr_done_t%0d got=%b exp=%b", t, done, exp_g); end
            tick();
            if (t == 4) begin
                req = '0; pready = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL rr_rdata got=%h exp=00", rdata); end
        m_last = 0;
    endtask

    task automatic test_timeout();
        tick();
        req = 4'b0100; req_wr = 4'b0000; pready = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL to_setup gnt=%b exp=0100", gnt); end
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            prdata = DW'($urandom);
            @(negedge clk);
            if (c >= TIMEOUT - 1) begin
                checks++; if (done !== ((c == TIMEOUT) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL to_done_c%0d got=%b exp=%b", c, done, (c == TIMEOUT) ? 4'b0100 : 4'b0000); end
            end else if (done !== 4'b0000) begin
                checks++; failures++; $display("FAIL to_early_done_c%0d got=%b exp=0000", c, done);
            end
        end
        tick();
        req = '0;
        @(negedge clk);
        checks++; if (psel !== 1'b0 || err !== 1'b1 || rdata !== exp_rdata) begin failures++; $display("FAIL to_end psel=%b err=%b rdata=%h exp=0/1/%h", psel, err, rdata, exp_rdata); end
        m_last = 2; exp_err = 1'b1;
    endtask

    task automatic test_reset_mid();
        tick();
        req = 4'b1000; req_wr = 4'b1000; pready = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (penable !== 1'b1 || gnt !== 4'b1000) begin failures++; $display("FAIL rm_access penable=%b gnt=%b exp=1/1000", penable, gnt); end
        tick();
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL rm_pre_done got=%b exp=0000", done); end
        tick();
        rstn = 1'b1; req = '1; req_wr = '1;
        @(negedge clk);
        checks++; if (psel !== 1'b0 || penable !== 1'b0 || done !== '0) begin failures++; $display("FAIL rm_dropped psel=%b penable=%b done=%b exp=0", psel, penable, done); end
        tick();
        pready = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rm_first gnt=%b exp=0001", gnt); end
        tick();
        @(negedge clk);
        tick();
        req = '0; pready = 1'b0;
        m_last = 0; exp_rdata = '0; exp_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask;
        logic [NREQ-1:0] exp_g;
        int              win;
        int              waits;
        logic            lat_wr;
        logic [AW-1:0]   lat_addr;
        logic [DW-1:0]   lat_wdata;
        for (int n = 0; n < 40; n++) begin
            // IDLE: present a fresh random request set
            tick();
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req = mask; req_wr = NREQ'($urandom);
            req_addr = (NREQ*AW)'($urandom); req_wdata = (NREQ*DW)'($urandom);
            pready = 1'($urandom); pslverr = 1'($urandom); prdata = DW'($urandom);
            @(negedge clk);
            checks++; if (psel !== 1'b0 || gnt !== '0 || done !== '0) begin failures++; $display("FAIL rnd_idle_%0d psel=%b gnt=%b done=%b exp=0", n, psel, gnt, done); end
            checks++; if (rdata !== exp_rdata || err !== exp_err) begin failures++; $display("FAIL rnd_status_%0d rdata=%h err=%b exp=%h/%b", n, rdata, err, exp_rdata, exp_err); end
            win = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (win < 0 && mask[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
            end
            exp_g = '0; exp_g[win] = 1'b1;
            lat_wr = req_wr[win];
            lat_addr = req_addr[win*AW +: AW];
            lat_wdata = req_wdata[win*DW +: DW];
            waits = $urandom_range(0, 3);
            $display("xfer %0d mask=%b owner=%0d wr=%0b addr=%h wdata=%h waits=%0d", n, mask, win, lat_wr, lat_addr, lat_wdata, waits);
            // SETUP: scramble requester inputs; the latched transfer must not move
            tick();
            req = NREQ'($urandom); req_wr = NREQ'($urandom);
            req_addr = (NREQ*AW)'($urandom); req_wdata = (NREQ*DW)'($urandom);
            pready = 1'($urandom); pslverr = 1'($urandom);
            @(negedge clk);
            checks++; if (psel !== 1'b1 || penable !== 1'b0 || gnt !== exp_g) begin failures++; $display("FAIL rnd_setup_%0d psel=%b penable=%b gnt=%b exp=1/0/%b", n, psel, penable, gnt, exp_g); end
            checks++; if (pwrite !== lat_wr || paddr !== lat_addr || pwdata !== lat_wdata) begin failures++; $display("FAIL rnd_latch_%0d pwrite=%b paddr=%h pwdata=%h exp=%b/%h/%h", n, pwrite, paddr, pwdata, lat_wr, lat_addr, lat_wdata); end
            checks++; if (err !== exp_err) begin failures++; $display("FAIL rnd_setup_err_%0d got=%b exp=%b", n, err, exp_err); end
            // ACCESS with random wait states
            for (int w = 0; w <= waits; w++) begin
                tick();
                req = NREQ'($urandom); req_addr = (NREQ*AW)'($urandom); req_wdata = (NREQ*DW)'($urandom);
                pready = (w == waits); pslverr = 1'($urandom); prdata = DW'($urandom);
                @(negedge clk);
                checks++; if (penable !== 1'b1 || gnt !== exp_g || paddr !== lat_addr || pwdata !== lat_wdata || pwrite !== lat_wr) begin failures++; $display("FAIL rnd_access_%0d_w%0d penable=%b gnt=%b paddr=%h pwdata=%h exp=1/%b/%h/%h", n, w, penable, gnt, paddr, pwdata, exp_g, lat_addr, lat_wdata); end
                checks++; if (done !== ((w == waits) ? exp_g : '0)) begin failures++; $display("FAIL rnd_done_%0d_w%0d got=%b exp=%b", n, w, done, (w == waits) ? exp_g : '0); end
                if (w == waits) begin
                    if (!lat_wr) exp_rdata = prdata;
                    exp_err = pslverr;
                    m_last = win;
                end
            end
        end
        tick();
        req = '0; pready = 1'b0;
        @(negedge clk);
        checks++; if (rdata !== exp_rdata || err !== exp_err) begin failures++; $display("FAIL rnd_final rdata=%h err=%b exp=%h/%b", rdata, err, exp_rdata, exp_err); end
    endtask

    initial begin
        rstn = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        m_last = NREQ - 1; exp_rdata = '0; exp_err = 1'b0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_slverr();
        test_rr_order();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
